// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared FSM state type, default sizes and the split_add reference function
package approx_mult_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_APPROX_BITS = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  // Low ab bits are ORed, the rest add exactly modulo 2^(pw-ab); results are limited to pw bits
  function automatic logic [63:0] split_add(input logic [63:0] x, input logic [63:0] y, input int pw, input int ab);
    logic [63:0] pw_m, lo_m;
    pw_m = (pw >= 64) ? '1 : (64'd1 << pw) - 64'd1;
    lo_m = ((ab >= 64) ? '1 : (64'd1 << ab) - 64'd1) & pw_m;
    return (((x | y) & lo_m) | (((x & ~lo_m) + (y & ~lo_m)) & ~lo_m)) & pw_m;
  endfunction
endpackage

// File: rtl/approx_seq_mult_if.sv
// approx_seq_mult_if: start/done handshake and operand/product bus of the multiplier
interface approx_seq_mult_if import approx_mult_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic start;
  logic [WIDTH-1:0] a, b;
  logic busy, done;
  logic [2*WIDTH-1:0] p;
  modport master (output start, a, b, input busy, done, p);
  modport slave (input start, a, b, output busy, done, p);
endinterface

// File: rtl/approx_split_add.sv
// approx_split_add: OR-combined low field, ripple full-adder high field with no carry between them
module approx_split_add #(
  parameter int WIDTH = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic [2*WIDTH-1:0] i_x,
  input  logic [2*WIDTH-1:0] i_y,
  output logic [2*WIDTH-1:0] o_sum
);
  localparam int HW = 2*WIDTH - APPROX_BITS;
  generate
    if (APPROX_BITS > 0) begin : g_lo
      assign o_sum[APPROX_BITS-1:0] = i_x[APPROX_BITS-1:0] | i_y[APPROX_BITS-1:0];
    end
    if (HW > 0) begin : g_hi
      logic [HW-1:0] w_c;
      assign w_c[0] = 1'b0;
      for (genvar i = 0; i < HW; i++) begin : g_fa
        logic w_a, w_b;
        assign w_a = i_x[APPROX_BITS+i];
        assign w_b = i_y[APPROX_BITS+i];
        assign o_sum[APPROX_BITS+i] = w_a ^ w_b ^ w_c[i];
        if (i < HW-1) begin : g_c
          assign w_c[i+1] = (w_a & w_b) | (w_c[i] & (w_a ^ w_b));
        end
      end
    end
  endgenerate
endmodule

// File: rtl/approx_seq_mult.sv
// approx_seq_mult: iterative shift-and-add multiplier with approximate low product bits
module approx_seq_mult import approx_mult_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input logic clk,
  input logic rst_n,
  approx_seq_mult_if.slave bus
);
  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH) > CNT_W ? $clog2(WIDTH) : CNT_W;
  state_t r_state, w_next;
  logic [PW-1:0] r_mcand, r_acc, r_p, w_addend, w_sum;
  logic [WIDTH-1:0] r_mplier;
  logic [CW-1:0] r_cnt;
  logic w_last, w_accept;
  assign w_accept = r_state == IDLE && bus.start;
  assign w_last = r_cnt == CW'(WIDTH-1);
  assign w_addend = r_mplier[r_cnt] ? r_mcand << r_cnt : '0;
  approx_split_add #(.WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS)) u_add (
    .i_x(r_acc),
    .i_y(w_addend),
    .o_sum(w_sum)
  );
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = RUN;
    if (r_state == RUN && w_last) w_next = DONE;
    if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplier <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_p <= '0;
    end else if (w_accept) begin
      r_mcand <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_p <= w_sum;
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  assign bus.p = r_p;
endmodule

// File: doc/approx_seq_mult.md
Name: approx_seq_mult

Overview:
- Iterative shift-and-add unsigned multiplier; consumes the sum/carry-style partial-product additions and produces the final product.
- Lower APPROX_BITS of every accumulation are approximate: bitwise OR, with no carry into the upper field. Upper bits use exact addition.
- Sits downstream of the adder primitives in the approximate multiplier datapath. Provides a start/done handshake to the test harness or host.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.
- APPROX_BITS, 4, number of low product bits computed approximately. Legal range 0..2*WIDTH; 0 means exact multiplication.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured on the accepted start
- b  input  WIDTH  multiplier; captured on the accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; p is valid in that cycle
- p  output  2*WIDTH  product; holds until the next accepted start completes

Behaviour:
- Reset: rst_n low at a rising edge forces state=IDLE, busy=0, done=0, p=0, internal accumulator/counter=0. Reset is synchronous only; it wins over every other event. Reset mid-RUN abandons the operation with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE: if start=1, latch a->mcand (zero-extended to 2*WIDTH), b->mplier, acc=0, cnt=0, go to RUN. Otherwise stay.
  - RUN: one multiplier bit per cycle. Addend = mplier[cnt] ? (mcand << cnt) : 0. acc = split_add(acc, addend). cnt++. After the edge that processes cnt=WIDTH-1, go to DONE and load p=final acc on that same edge.
  - DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- split_add(x,y):
  - Low field [APPROX_BITS-1:0] = x_lo | y_lo.
  - High field [2W-1:APPROX_BITS] = x_hi + y_hi, modulo 2^(2W-APPROX_BITS).
  - No carry crosses from the low field to the high field.
  - APPROX_BITS=0: plain exact add. APPROX_BITS=2W: pure OR.
- Latency: start sampled at edge E0. done=1 in the cycle after edge E_WIDTH, i.e. WIDTH cycles after acceptance. Throughput is one result per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored and not queued. Operands changing after acceptance have no effect.
- start=1 held continuously: a new operation is accepted on the first IDLE cycle after DONE.
- p is 2*WIDTH wide. The exact product cannot overflow; the approximate product is always ≤ exact and cannot overflow.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package approx_mult_pkg:
  - state enum (IDLE/RUN/DONE, 2-bit encoding)
  - localparam for counter width, clog2(WIDTH)
  - pure function helper for the reference model of split_add, reused by the bench
- One natural sub-module: approx_split_add. It is combinational, parameterised by WIDTH/APPROX_BITS, and built from the existing half/full adder cells for the exact field plus OR gates for the low field.
- FSM, counter and registers stay in approx_seq_mult.

Test Plan:
- APPROX_BITS=0, a=13, b=11, start 1 cycle -> busy=1 for 9 cycles; done pulses 8 cycles after acceptance; p=143; p holds 143 afterwards.
- APPROX_BITS=4, a=15, b=15 -> p=0x00BF (191); exact 225. Intermediate acc values 0x0F, 0x1F, 0x4F, 0xBF.
- APPROX_BITS=0, a=255, b=255 -> p=65025 (0xFE01). Also a=0, b=200 -> p=0. Also a=200, b=0 -> p=0.
- Pulse start again 3 cycles into RUN with different operands -> ignored; result equals the first operands' product; exactly one done pulse.
- Drive rst_n=0 for one edge at RUN cnt=4 -> next cycle busy=0, done=0, p=0; no done pulse follows. A fresh start then completes normally.
- Hold start=1 for 30 cycles with a=3, b=5, APPROX_BITS=0 -> back-to-back operations every WIDTH+2 cycles; each done pulse carries p=15. Randomised sweep against the package model: zero mismatches.
